// File: rtl/lcd_state_machine_pkg.sv
// Shared definitions for the HD44780 write-only controller: FSM states,
// command bytes, step-table indices and step-table helper functions.
package lcd_state_machine_pkg;

    localparam int CNT_W  = 32;
    localparam int STEP_W = 6;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWR_WAIT  = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_HOLD_WAIT = 3'd4,
        ST_NEXT      = 3'd5
    } lcdStateT;

    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] CMD_DISPLAY_OFF  = 8'h08;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_LINE1        = 8'h80;
    localparam logic [7:0] CMD_LINE2        = 8'hC0;

    localparam logic [STEP_W-1:0] STEP_INIT_FIRST  = 6'd0;
    localparam logic [STEP_W-1:0] STEP_LINE1_ADDR  = 6'd7;
    localparam logic [STEP_W-1:0] STEP_LINE1_FIRST = 6'd8;
    localparam logic [STEP_W-1:0] STEP_LINE1_LAST  = 6'd23;
    localparam logic [STEP_W-1:0] STEP_LINE2_ADDR  = 6'd24;
    localparam logic [STEP_W-1:0] STEP_LINE2_FIRST = 6'd25;
    localparam logic [STEP_W-1:0] STEP_LAST        = 6'd40;

    function automatic logic stepIsChar(input logic [STEP_W-1:0] step);
        return ((step >= STEP_LINE1_FIRST) && (step <= STEP_LINE1_LAST)) ||
               ((step >= STEP_LINE2_FIRST) && (step <= STEP_LAST));
    endfunction

    // Line 1 chars map to addresses 0..15, line 2 chars to 16..31.
    function automatic logic [4:0] stepCharAddr(input logic [STEP_W-1:0] step);
        logic [STEP_W-1:0] offset;
        offset = (step <= STEP_LINE1_LAST) ? (step - STEP_LINE1_FIRST)
                                           : (step - STEP_LINE2_FIRST + 6'd16);
        return offset[4:0];
    endfunction

    function automatic logic [7:0] stepCommand(input logic [STEP_W-1:0] step);
        logic [7:0] cmd;
        case (step)
            6'd0, 6'd1, 6'd2: cmd = CMD_FUNCTION_SET;
            6'd3:             cmd = CMD_DISPLAY_OFF;
            6'd4:             cmd = CMD_CLEAR;
            6'd5:             cmd = CMD_ENTRY_MODE;
            6'd6:             cmd = CMD_DISPLAY_ON;
            STEP_LINE1_ADDR:  cmd = CMD_LINE1;
            STEP_LINE2_ADDR:  cmd = CMD_LINE2;
            default:          cmd = 8'h00;
        endcase
        return cmd;
    endfunction

    // The refresh loop wraps from the last char back to the line-1 address command.
    function automatic logic [STEP_W-1:0] stepAdvance(input logic [STEP_W-1:0] step);
        return (step == STEP_LAST) ? STEP_LINE1_ADDR : (step + 6'd1);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Down-counter timing one FSM state: start loads the duration in clocks,
// done is high during the last clock of that duration.
module lcd_delay_counter
    import lcd_state_machine_pkg::*;
(
    input  logic             clk,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             start,
    output logic             done,
    input  logic             resetN
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            count <= '0;
        end else if (start) begin
            // A state entered with start lasts loadValue clocks; zero behaves as one.
            count <= (loadValue == '0) ? '0 : (loadValue - 1'b1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_state_machine.sv
// HD44780 8-bit write-only controller: power-on wait, init command sequence,
// then an endless refresh of two 16-char lines from external text memory.
module lcd_state_machine
    import lcd_state_machine_pkg::*;
#(
    parameter int POWER_WAIT_CYC = 1000000,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int SETUP_CYC      = 2,
    parameter int EN_CYC         = 25
) (
    input  logic       clk,
    input  logic       lcdOnIn,
    input  logic [7:0] dataIn,
    output logic [7:0] lcdBus,
    output logic [4:0] addrToRead,
    output logic       lcdOnOut,
    output logic       lcdReadWriteSel,
    output logic       lcdRsSelect,
    output logic       lcdEnableOut,
    output logic       errorLed,
    input  logic       resetN
);

    localparam logic [CNT_W-1:0] POWER_LOAD = CNT_W'(POWER_WAIT_CYC);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYC);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT_CYC);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYC);

    lcdStateT          state;
    lcdStateT          nextState;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] stepAfter;
    logic [STEP_W-1:0] entryStep;
    logic              entryIsChar;
    logic              enterSetup;
    logic              enterNext;
    logic              faultNow;
    logic              isClearCmd;
    logic              cntStart;
    logic [CNT_W-1:0]  cntLoad;
    logic              cntDone;

    lcd_delay_counter u_delay (
        .clk       (clk),
        .loadValue (cntLoad),
        .start     (cntStart),
        .done      (cntDone),
        .resetN    (resetN)
    );

    // Clear and home need the long execution wait; the latched bus identifies them.
    assign isClearCmd = !lcdRsSelect && ((lcdBus == CMD_CLEAR) || (lcdBus == CMD_HOME));

    always_comb begin
        nextState = state;
        cntStart  = 1'b0;
        cntLoad   = '0;
        faultNow  = 1'b0;
        stepAfter = stepAdvance(step);

        if (step > STEP_LAST) begin
            faultNow  = 1'b1;
            nextState = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    if (lcdOnIn) begin
                        nextState = ST_PWR_WAIT;
                        cntStart  = 1'b1;
                        cntLoad   = POWER_LOAD;
                    end
                end
                ST_PWR_WAIT: begin
                    if (cntDone) begin
                        nextState = ST_SETUP;
                        cntStart  = 1'b1;
                        cntLoad   = SETUP_LOAD;
                    end
                end
                ST_SETUP: begin
                    if (cntDone) begin
                        nextState = ST_PULSE;
                        cntStart  = 1'b1;
                        cntLoad   = EN_LOAD;
                    end
                end
                ST_PULSE: begin
                    if (cntDone) begin
                        nextState = ST_HOLD_WAIT;
                        cntStart  = 1'b1;
                        cntLoad   = isClearCmd ? CLEAR_LOAD : CMD_LOAD;
                    end
                end
                ST_HOLD_WAIT: begin
                    if (cntDone) begin
                        nextState = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    nextState = ST_SETUP;
                    cntStart  = 1'b1;
                    cntLoad   = SETUP_LOAD;
                end
                default: begin
                    faultNow  = 1'b1;
                    nextState = ST_OFF;
                end
            endcase
        end

        if (!lcdOnIn) begin
            nextState = ST_OFF;
        end
    end

    // SETUP is entered either from power-up (step 0) or from NEXT (advanced step).
    assign entryStep   = (state == ST_NEXT) ? stepAfter : STEP_INIT_FIRST;
    assign entryIsChar = stepIsChar(entryStep);
    assign enterSetup  = (nextState == ST_SETUP) && (state != ST_SETUP);
    assign enterNext   = (state == ST_HOLD_WAIT) && (nextState == ST_NEXT);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state           <= ST_OFF;
            step            <= STEP_INIT_FIRST;
            lcdBus          <= 8'h00;
            addrToRead      <= 5'd0;
            lcdOnOut        <= 1'b0;
            lcdReadWriteSel <= 1'b0;
            lcdRsSelect     <= 1'b0;
            lcdEnableOut    <= 1'b0;
            errorLed        <= 1'b0;
        end else begin
            state           <= nextState;
            lcdOnOut        <= lcdOnIn;
            lcdReadWriteSel <= 1'b0;
            lcdEnableOut    <= (nextState == ST_PULSE);
            if (faultNow) begin
                errorLed <= 1'b1;
            end
            if (nextState == ST_OFF) begin
                step        <= STEP_INIT_FIRST;
                lcdBus      <= 8'h00;
                lcdRsSelect <= 1'b0;
            end else if (enterSetup) begin
                step        <= entryStep;
                lcdRsSelect <= entryIsChar;
                lcdBus      <= entryIsChar ? dataIn : stepCommand(entryStep);
            end
            // Address leads the data sample by the NEXT clock to cover memory latency.
            if (enterNext && stepIsChar(stepAfter)) begin
                addrToRead <= stepCharAddr(stepAfter);
            end
        end
    end

endmodule

// File: tb/tb_lcd_state_machine.sv
// Self-checking bench for lcd_state_machine: observes E pulses on the bus and
// compares them to an expected pulse list built from the command/text layout.
module tb_lcd_state_machine;
    import lcd_state_machine_pkg::*;

    localparam int POWER_WAIT_CYC = 10;
    localparam int CMD_WAIT_CYC   = 4;
    localparam int CLEAR_WAIT_CYC = 8;
    localparam int SETUP_CYC      = 1;
    localparam int EN_CYC         = 2;
    localparam int BUDGET         = 300;

    logic       clk = 1'b0;
    logic       resetN;
    logic       lcdOnIn;
    logic [7:0] dataIn;
    logic [7:0] lcdBus;
    logic [4:0] addrToRead;
    logic       lcdOnOut;
    logic       lcdReadWriteSel;
    logic       lcdRsSelect;
    logic       lcdEnableOut;
    logic       errorLed;

    logic [7:0]  mem [32];
    logic [13:0] exp_q[$];          // {rs, charAddr, commandByte}
    logic [7:0]  initCmds [7];
    int          cycle = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    int          prevFall = 0;
    logic        prevClear = 1'b0;

    lcd_state_machine #(
        .POWER_WAIT_CYC (POWER_WAIT_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
        .SETUP_CYC      (SETUP_CYC),
        .EN_CYC         (EN_CYC)
    ) dut (
        .clk             (clk),
        .lcdOnIn         (lcdOnIn),
        .dataIn          (dataIn),
        .lcdBus          (lcdBus),
        .addrToRead      (addrToRead),
        .lcdOnOut        (lcdOnOut),
        .lcdReadWriteSel (lcdReadWriteSel),
        .lcdRsSelect     (lcdRsSelect),
        .lcdEnableOut    (lcdEnableOut),
        .errorLed        (errorLed),
        .resetN          (resetN)
    );

    // Clock and cycle index (cycle == number of rising edges seen so far).
    always #10 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Asynchronous text memory.
    assign dataIn = mem[addrToRead];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", testsRun, testsFailed);
        $fatal(1, "watchdog");
    end

    // Called at a negedge with E low; returns the fields latched by the next E pulse.
    task automatic capturePulse(output logic [7:0] bus, output logic rs, output logic [4:0] addr,
                                output int riseCyc, output int width, output logic timedOut);
        int n;
        bus = 8'h00; rs = 1'b0; addr = 5'd0; riseCyc = 0; width = 0; timedOut = 1'b0; n = 0;
        while (lcdEnableOut !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (lcdEnableOut !== 1'b1) begin
            timedOut = 1'b1;
            return;
        end
        riseCyc = cycle; bus = lcdBus; rs = lcdRsSelect; addr = addrToRead;
        while (lcdEnableOut === 1'b1 && width < BUDGET) begin
            width++;
            @(negedge clk);
        end
    endtask

    function automatic int expGap(input logic afterClear);
        return (afterClear ? CLEAR_WAIT_CYC : CMD_WAIT_CYC) + SETUP_CYC + 1;
    endfunction

    task automatic test_reset();
        resetN = 1'b0;
        lcdOnIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            testsRun++;
            if ({lcdBus, addrToRead, lcdOnOut, lcdReadWriteSel, lcdRsSelect, errorLed} !== 17'd0) begin
                testsFailed++;
                $display("FAIL reset_outputs: got bus=%h addr=%0d on=%b rw=%b rs=%b err=%b, want all 0",
                         lcdBus, addrToRead, lcdOnOut, lcdReadWriteSel, lcdRsSelect, errorLed);
            end
            testsRun++;
            if (lcdEnableOut !== 1'b0) begin
                testsFailed++;
                $display("FAIL reset_e: got E=%b, want 0", lcdEnableOut);
            end
        end
    endtask

    task automatic test_init_sequence();
        logic [7:0] bus; logic rs; logic [4:0] addr; int rise, width, raiseCyc; logic to;
        lcdOnIn = 1'b0;
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (lcdOnOut !== 1'b0 || lcdEnableOut !== 1'b0) begin
            testsFailed++;
            $display("FAIL idle_off: got on=%b E=%b, want 0 0", lcdOnOut, lcdEnableOut);
        end
        raiseCyc = cycle;
        lcdOnIn = 1'b1;
        @(negedge clk);
        testsRun++;
        if (lcdOnOut !== 1'b1) begin
            testsFailed++;
            $display("FAIL lcd_on_delay: got lcdOnOut=%b one clock after rise, want 1", lcdOnOut);
        end
        for (int i = 0; i < 7; i++) begin
            capturePulse(bus, rs, addr, rise, width, to);
            testsRun++;
            if (to) begin
                testsFailed++;
                $display("FAIL init_timeout: no E pulse for init step %0d within %0d clocks", i, BUDGET);
                return;
            end
            if (i == 0) begin
                testsRun++;
                if (rise - (raiseCyc + 1) !== POWER_WAIT_CYC + SETUP_CYC) begin
                    testsFailed++;
                    $display("FAIL first_e_latency: got %0d clocks, want %0d",
                             rise - (raiseCyc + 1), POWER_WAIT_CYC + SETUP_CYC);
                end
            end else begin
                testsRun++;
                if (rise - prevFall !== expGap(prevClear)) begin
                    testsFailed++;
                    $display("FAIL init_gap%0d: got %0d clocks, want %0d", i, rise - prevFall, expGap(prevClear));
                end
            end
            if (bus !== initCmds[i] || rs !== 1'b0) begin
                testsFailed++;
                $display("FAIL init_cmd%0d: got bus=%h rs=%b, want bus=%h rs=0", i, bus, rs, initCmds[i]);
            end
            testsRun++;
            if (width !== EN_CYC) begin
                testsFailed++;
                $display("FAIL init_width%0d: got %0d, want %0d", i, width, EN_CYC);
            end
            prevFall = rise + width;
            prevClear = (initCmds[i] == 8'h01) || (initCmds[i] == 8'h02);
        end
    endtask

    // Expected refresh: line-1 address, 16 chars, line-2 address, 16 chars, line-1 again.
    task automatic test_refresh_loop(input bit randomText, input bit includeLine1Cmd);
        logic [7:0] bus; logic rs; logic [4:0] addr; int rise, width; logic to;
        logic [13:0] e; logic [7:0] want; logic wantRs; logic [4:0] wantAddr;
        if (randomText) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
            mem[5] = 8'h80; mem[20] = 8'h00; mem[31] = 8'hFF;
        end else begin
            for (int i = 0; i < 32; i++) mem[i] = 8'h80;
        end
        exp_q.delete();
        if (includeLine1Cmd) exp_q.push_back({1'b0, 5'd0, 8'h80});
        for (int a = 0; a < 16; a++) exp_q.push_back({1'b1, 5'(a), 8'h00});
        exp_q.push_back({1'b0, 5'd0, 8'hC0});
        for (int a = 16; a < 32; a++) exp_q.push_back({1'b1, 5'(a), 8'h00});
        exp_q.push_back({1'b0, 5'd0, 8'h80});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wantRs = e[13];
            wantAddr = e[12:8];
            want = wantRs ? mem[wantAddr] : e[7:0];
            capturePulse(bus, rs, addr, rise, width, to);
            testsRun++;
            if (to) begin
                testsFailed++;
                $display("FAIL refresh_timeout: no E pulse within %0d clocks", BUDGET);
                return;
            end
            if (bus !== want || rs !== wantRs) begin
                testsFailed++;
                $display("FAIL refresh_data: got bus=%h rs=%b, want bus=%h rs=%b", bus, rs, want, wantRs);
            end
            if (wantRs) begin
                testsRun++;
                if (addr !== wantAddr) begin
                    testsFailed++;
                    $display("FAIL refresh_addr: got %0d, want %0d", addr, wantAddr);
                end
            end
            testsRun++;
            if (width !== EN_CYC || rise - prevFall !== expGap(prevClear)) begin
                testsFailed++;
                $display("FAIL refresh_timing: got width=%0d gap=%0d, want %0d %0d",
                         width, rise - prevFall, EN_CYC, expGap(prevClear));
            end
            testsRun++;
            if (errorLed !== 1'b0) begin
                testsFailed++;
                $display("FAIL refresh_error: got errorLed=%b, want 0", errorLed);
            end
            prevFall = rise + width;
            prevClear = 1'b0;
        end
    endtask

    task automatic test_power_cycle();
        logic [7:0] bus; logic rs; logic [4:0] addr; int rise, width, raiseCyc, n; logic to;
        int skip;
        skip = $urandom_range(0, 5);
        for (int i = 0; i < skip; i++) capturePulse(bus, rs, addr, rise, width, to);
        n = 0;
        while (lcdEnableOut !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (lcdEnableOut !== 1'b1) begin
            testsFailed++;
            $display("FAIL off_wait: no E pulse within %0d clocks", BUDGET);
            return;
        end
        lcdOnIn = 1'b0;
        @(negedge clk);
        testsRun++;
        if (lcdEnableOut !== 1'b0 || lcdBus !== 8'h00 || lcdRsSelect !== 1'b0 || lcdOnOut !== 1'b0) begin
            testsFailed++;
            $display("FAIL off_drop: got E=%b bus=%h rs=%b on=%b, want 0 00 0 0",
                     lcdEnableOut, lcdBus, lcdRsSelect, lcdOnOut);
        end
        testsRun++;
        if (dut.state !== ST_OFF) begin
            testsFailed++;
            $display("FAIL off_state: got %0d, want %0d", dut.state, ST_OFF);
        end
        repeat ($urandom_range(1, 5)) @(negedge clk);
        raiseCyc = cycle;
        lcdOnIn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            capturePulse(bus, rs, addr, rise, width, to);
            testsRun++;
            if (to) begin
                testsFailed++;
                $display("FAIL reinit_timeout: step %0d", i);
                return;
            end
            if (bus !== initCmds[i] || rs !== 1'b0) begin
                testsFailed++;
                $display("FAIL reinit_cmd%0d: got bus=%h rs=%b, want bus=%h rs=0", i, bus, rs, initCmds[i]);
            end
            if (i == 0) begin
                testsRun++;
                if (rise - (raiseCyc + 1) !== POWER_WAIT_CYC + SETUP_CYC) begin
                    testsFailed++;
                    $display("FAIL reinit_latency: got %0d clocks, want %0d",
                             rise - (raiseCyc + 1), POWER_WAIT_CYC + SETUP_CYC);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        n = 0;
        while (lcdEnableOut !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (lcdEnableOut !== 1'b1) begin
            testsFailed++;
            $display("FAIL midreset_wait: no E pulse within %0d clocks", BUDGET);
            return;
        end
        resetN = 1'b0;
        @(negedge clk);
        testsRun++;
        if (lcdEnableOut !== 1'b0 || lcdBus !== 8'h00 || lcdOnOut !== 1'b0) begin
            testsFailed++;
            $display("FAIL midreset_drop: got E=%b bus=%h on=%b, want 0 00 0", lcdEnableOut, lcdBus, lcdOnOut);
        end
        resetN = 1'b1;
    endtask

    task automatic test_illegal_encoding();
        @(negedge clk);
        force dut.state = lcdStateT'(3'd7);
        @(negedge clk);
        release dut.state;
        for (int i = 0; i < 6; i++) begin
            testsRun++;
            if (errorLed !== 1'b1) begin
                testsFailed++;
                $display("FAIL illegal_state_sticky%0d: got errorLed=%b, want 1", i, errorLed);
            end
            lcdOnIn = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        resetN = 1'b0;
        @(negedge clk);
        testsRun++;
        if (errorLed !== 1'b0) begin
            testsFailed++;
            $display("FAIL illegal_state_clear: got errorLed=%b after reset, want 0", errorLed);
        end
        resetN = 1'b1;
        lcdOnIn = 1'b1;
        repeat (3) @(negedge clk);
        force dut.step = 6'd50;
        @(negedge clk);
        release dut.step;
        @(negedge clk);
        testsRun++;
        if (errorLed !== 1'b1 || lcdEnableOut !== 1'b0) begin
            testsFailed++;
            $display("FAIL illegal_step: got errorLed=%b E=%b, want 1 0", errorLed, lcdEnableOut);
        end
        resetN = 1'b0;
        @(negedge clk);
        testsRun++;
        if (errorLed !== 1'b0) begin
            testsFailed++;
            $display("FAIL illegal_step_clear: got errorLed=%b after reset, want 0", errorLed);
        end
        resetN = 1'b1;
    endtask

    initial begin
        initCmds[0] = 8'h38; initCmds[1] = 8'h38; initCmds[2] = 8'h38; initCmds[3] = 8'h08;
        initCmds[4] = 8'h01; initCmds[5] = 8'h06; initCmds[6] = 8'h0C;
        for (int i = 0; i < 32; i++) mem[i] = 8'h80;
        test_reset();
        test_init_sequence();
        test_refresh_loop(1'b0, 1'b1);
        test_refresh_loop(1'b1, 1'b0);
        test_power_cycle();
        test_reset_mid_pulse();
        test_illegal_encoding();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
